// File: rtl/bcd_display_scanner.sv
// -----------------------------------------------------------------------------
// bcd_display_scanner
//
// Latches a three-digit BCD value and time-multiplexes it onto one common
// 7-segment bus with one-hot digit enables. Leading zeros are blanked and
// invalid (>9) nibbles are shown as a dash and flagged on err. New values are
// held in a pending register and only swapped into the displayed register at
// a frame boundary, so one scan never mixes old and new digits.
//
// Parameters:
//   REFRESH_DIV  clock cycles each digit is held (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bcd_in      [11:8] hundreds, [7:4] tens, [3:0] ones
//   load        capture qualifier for bcd_in
//   seg         segments {g,f,e,d,c,b,a}, active-high
//   an          one-hot digit enable: 001 ones, 010 tens, 100 hundreds
//   frame_done  pulse on the last cycle of each scan frame
//   err         high while any displayed nibble is > 9
// -----------------------------------------------------------------------------
module bcd_display_scanner #(
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame_done,
    output logic        err
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [11:0]   disp_q,  disp_d;
    logic [11:0]   pend_val_q, pend_val_d;
    logic          pend_q,  pend_d;

    logic          tc;
    logic          fb;

    assign tc = (presc_q == PS_MAX);
    assign fb = tc && (digit_q == 2'd2);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        presc_d    = tc ? '0 : presc_q + 1'b1;

        digit_d    = digit_q;
        if (digit_q == 2'd3) begin
            digit_d = 2'd0;
        end else if (tc) begin
            digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
        end

        disp_d     = disp_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;

        if (fb) begin
            // A load on the boundary cycle bypasses the pending register and
            // supersedes whatever was waiting there.
            if (load) begin
                disp_d = bcd_in;
            end else if (pend_q) begin
                disp_d = pend_val_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            pend_val_d = bcd_in;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            digit_q    <= '0;
            disp_q     <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            digit_q    <= digit_d;
            disp_q     <= disp_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered state only)
    // ------------------------------------------------------------------
    logic [3:0] hund, tens, ones;
    logic [3:0] nib;
    logic       blank;
    logic [6:0] seg_raw;

    assign hund = disp_q[11:8];
    assign tens = disp_q[7:4];
    assign ones = disp_q[3:0];

    always_comb begin
        nib   = '0;
        an    = '0;
        blank = 1'b1;
        case (digit_q)
            2'd0: begin
                nib   = ones;
                an    = 3'b001;
                blank = 1'b0;
            end
            2'd1: begin
                nib   = tens;
                an    = 3'b010;
                blank = (hund == 4'd0) && (tens == 4'd0);
            end
            2'd2: begin
                nib   = hund;
                an    = 3'b100;
                blank = (hund == 4'd0);
            end
            default: begin
                nib   = '0;
                an    = '0;
                blank = 1'b1;
            end
        endcase
    end

    always_comb begin
        seg_raw = 7'h40;
        case (nib)
            4'd0: seg_raw = 7'h3F;
            4'd1: seg_raw = 7'h06;
            4'd2: seg_raw = 7'h5B;
            4'd3: seg_raw = 7'h4F;
            4'd4: seg_raw = 7'h66;
            4'd5: seg_raw = 7'h6D;
            4'd6: seg_raw = 7'h7D;
            4'd7: seg_raw = 7'h07;
            4'd8: seg_raw = 7'h7F;
            4'd9: seg_raw = 7'h6F;
            default: seg_raw = 7'h40;
        endcase
    end

    assign seg        = blank ? 7'h00 : seg_raw;
    assign frame_done = fb;
    assign err        = (hund > 4'd9) || (tens > 4'd9) || (ones > 4'd9);

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Downstream consumer of the 12-bit BCD word produced by the binary-to-BCD converter. Latches a three-digit BCD value and time-multiplexes it onto a single common 7-segment bus with one-hot digit enables. Blanks leading zeros and flags invalid nibbles. Swaps in new values only at frame boundaries, so a digit scan never shows a mix of old and new values.

## Interface
- REFRESH_DIV, 4: clock cycles each digit is held; legal range ≥1.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- bcd_in  input  12  BCD word: [11:8] hundreds, [7:4] tens, [3:0] ones.
- load  input  1  one-cycle qualifier; captures bcd_in on a rising edge where load=1.
- seg  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
- an  output  3  one-hot digit enable, active-high: 001 ones, 010 tens, 100 hundreds.
- frame_done  output  1  one-cycle pulse on the last cycle of each scan frame.
- err  output  1  high while any nibble of the displayed value is >9.

## Operation
- State registers:
  - prescaler, $clog2(REFRESH_DIV) bits, minimum 1 bit.
  - digit index, 0..2.
  - disp_reg, 12 bits.
  - pend_reg, 12 bits.
  - pend flag.
- Reset (async, rst_n=0): prescaler=0, digit=0, disp_reg=0, pend_reg=0, pend=0.
  - Resulting outputs: an=001, seg=7'h3F, frame_done=0, err=0.
- Prescaler counts 0..REFRESH_DIV-1 and then wraps. Terminal count (tc) = prescaler==REFRESH_DIV-1.
- On tc, digit advances 0→1→2→0. A digit index of 3 is unreachable; if it ever occurs, the next edge forces digit=0.
- Frame boundary (fb) = tc && digit==2. frame_done = fb, decoded combinationally from registered state.
- Load handling:
  - load && !fb: pend_reg<=bcd_in, pend<=1. Repeated loads before fb overwrite pend_reg, so the last load wins.
  - fb && !load && pend: disp_reg<=pend_reg, pend<=0.
  - fb && load: disp_reg<=bcd_in directly, pend<=0. Any older pending value is discarded.
  - fb && !load && !pend: disp_reg unchanged.
- Digit selection: nibble = disp_reg[4*digit+3 : 4*digit]. an = 1<<digit.
- Segment decode (seg values by nibble):
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66.
  - 5→6D, 6→7D, 7→07, 8→7F, 9→6F.
  - Any nibble 10..15→40 (dash).
- Leading-zero blanking (seg=00, an still asserted):
  - Hundreds is blanked when hundreds==0.
  - Tens is blanked when hundreds==0 && tens==0.
  - Ones is never blanked.
  - An invalid nibble is nonzero, so it is never blanked and never causes a lower digit to blank.
- err = OR over the three disp_reg nibbles of (nibble>9). It is combinational from disp_reg and changes only when disp_reg changes.
- seg, an, frame_done and err are decoded from registered state only. They have no combinational path from bcd_in or load.

## Timing
- Each digit is enabled for exactly REFRESH_DIV consecutive cycles. A frame is 3×REFRESH_DIV cycles.
- With REFRESH_DIV=1, tc is high every cycle: the digit advances every cycle and frame_done pulses every third cycle.
- New value visibility: disp_reg updates on the edge that ends the fb cycle. The new value first appears on digit 0 in the following cycle.
- Latency from a load edge to visible display is 1 to 3×REFRESH_DIV cycles. The worst case is a load on the first cycle of a frame.
- A load on the fb cycle itself becomes visible on the very next cycle.
- Reset mid-frame: outputs return to their reset values immediately (asynchronous). Scanning restarts at digit 0 with prescaler 0 on the first edge after deassertion. Any pending value is lost.
- Deassertion of rst_n must meet recovery/removal requirements relative to clk. Synchronizing rst_n is outside this block.

## Test plan
- Reset, then load 12'h255 with REFRESH_DIV=4 → next frame shows an/seg = 001/6D, 010/6D, 100/5B, each for 4 cycles; frame_done pulses every 12 cycles; err=0.
- Load 12'h042 → 001/5B, 010/66, 100/00. Load 12'h007 → 001/07, 010/00, 100/00. Load 12'h000 → 001/3F, 010/00, 100/00.
- Load 12'h123 in frame cycle 2, then 12'h089 in cycle 7 of the same frame → next frame shows only 089 (001/6F, 010/7F, 100/00); 123 is never displayed.
- Load 12'h1A3 → 001/4F, 010/40, 100/06; err=1. Then load 12'h100 → err returns to 0 on the first cycle of the next frame, and tens shows 3F (not blanked).
- Load coincident with the frame_done cycle (pend already holding 12'h111, load 12'h222) → disp_reg=222 on the next cycle; 111 is never shown; pend=0.
- Assert rst_n=0 mid-frame while showing 255 on tens → an=001, seg=3F with no clock edge. After release, no frame_done occurs until 12 cycles have elapsed.
